// File: rtl/stop_watch_lap.sv
// ---------------------------------------------------------------------------
// stop_watch_lap
//
// BCD stopwatch for the seven-segment display path. Counts in DIGITS decimal
// digits, one step every TICK_DIV enabled clock cycles, either up or down.
// Supports a preset load, a lap hold that freezes the display while the count
// keeps running underneath, and sticky overflow / done flags.
//
// Parameters
//   TICK_DIV  clock cycles per count step (>= 1)
//   DIGITS    number of BCD digits (1..8)
//
// Ports
//   clock       in   single clock, rising edge
//   reset       in   asynchronous, active-high; clears all state
//   start       in   level; prescaler advances while high
//   clear       in   one-cycle pulse; zeroes count, prescaler, flags, lap
//   load        in   one-cycle pulse; count <- preset (nibbles clamped to 9)
//   preset      in   BCD preset, digit n in bits [4n+3:4n]
//   mode        in   0 = count up, 1 = count down
//   lap         in   one-cycle pulse; toggles the lap hold
//   digits      out  displayed BCD value (registered), digit 0 in [3:0]
//   lap_active  out  display is frozen on the captured lap value
//   overflow    out  sticky; the up count wrapped from all-9s
//   done        out  sticky; the down count reached zero
//   running     out  combinational: start & ~(mode & done)
// ---------------------------------------------------------------------------
module stop_watch_lap #(
    parameter int TICK_DIV = 4,
    parameter int DIGITS   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  mode,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  lap_active,
    output logic                  overflow,
    output logic                  done,
    output logic                  running
);

    localparam int W     = 4 * DIGITS;
    // TICK_DIV = 1 still needs a one-bit prescaler so the compare is legal.
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    // -----------------------------------------------------------------------
    // BCD helper functions
    // -----------------------------------------------------------------------

    // Force every nibble into the 0..9 range; out-of-range nibbles become 9.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // True when every digit is 9 (the increment would wrap).
    function automatic logic bcd_all_nines(input logic [W-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

    // Ripple increment: a digit at 9 goes to 0 and carries upward.
    // All-9s wraps to all-0s; the caller flags the overflow.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple decrement: a digit at 0 goes to 9 and borrows upward.
    // Only called with a non-zero operand.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [W-1:0]     cnt_q,    cnt_d;
    logic [W-1:0]     hold_q,   hold_d;
    logic [W-1:0]     digits_q, digits_d;
    logic [PRE_W-1:0] pre_q,    pre_d;
    logic             lap_q,    lap_d;
    logic             ovf_q,    ovf_d;
    logic             done_q,   done_d;

    logic             run_c;
    logic             tick_c;
    logic [W-1:0]     dec_c;

    // A finished countdown parks the prescaler until mode or flags change.
    assign run_c  = start & ~(mode & done_q);
    assign tick_c = run_c & (pre_q == PRE_MAX);
    assign dec_c  = bcd_dec(cnt_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        hold_d = hold_q;
        pre_d  = pre_q;
        lap_d  = lap_q;
        ovf_d  = ovf_q;
        done_d = done_q;

        if (clear) begin
            cnt_d  = '0;
            hold_d = '0;
            pre_d  = '0;
            lap_d  = 1'b0;
            ovf_d  = 1'b0;
            done_d = 1'b0;
        end else if (load) begin
            // A lap pulse arriving with load is dropped; the hold is released.
            cnt_d  = bcd_clamp(preset);
            pre_d  = '0;
            lap_d  = 1'b0;
            ovf_d  = 1'b0;
            done_d = 1'b0;
        end else begin
            if (run_c) begin
                pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
            end

            // The lap snapshot takes the pre-edge count, i.e. what is being
            // displayed right now, independent of a tick on the same edge.
            if (lap) begin
                if (!lap_q) begin
                    hold_d = cnt_q;
                    lap_d  = 1'b1;
                end else begin
                    lap_d  = 1'b0;
                end
            end

            if (tick_c) begin
                if (!mode) begin
                    cnt_d = bcd_inc(cnt_q);
                    if (bcd_all_nines(cnt_q)) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    // Zero is a floor: ticking at zero re-asserts done.
                    if (cnt_q == '0) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = dec_c;
                        if (dec_c == '0) begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
        end

        // The display is registered from next-state so it moves with the count.
        digits_d = lap_d ? hold_d : cnt_d;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            hold_q   <= '0;
            digits_q <= '0;
            pre_q    <= '0;
            lap_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            digits_q <= digits_d;
            pre_q    <= pre_d;
            lap_q    <= lap_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign digits     = digits_q;
    assign lap_active = lap_q;
    assign overflow   = ovf_q;
    assign done       = done_q;
    assign running    = run_c;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Self-checking bench for stop_watch_lap (TICK_DIV = 4, DIGITS = 4).
module tb_stop_watch_lap;

    localparam int TD   = 4;
    localparam int ND   = 4;
    localparam int W    = 4 * ND;
    localparam int MAXV = 9999;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         clear = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] preset = '0;
    logic         mode  = 1'b0;
    logic         lap   = 1'b0;
    logic [W-1:0] digits;
    logic         lap_active;
    logic         overflow;
    logic         done;
    logic         running;

    int checks = 0;
    int errors = 0;

    stop_watch_lap #(.TICK_DIV(TD), .DIGITS(ND)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .load       (load),
        .preset     (preset),
        .mode       (mode),
        .lap        (lap),
        .digits     (digits),
        .lap_active (lap_active),
        .overflow   (overflow),
        .done       (done),
        .running    (running)
    );

    always #5 clock = ~clock;

    // ---------------- reference model (integer arithmetic) ----------------
    int m_cnt, m_pre, m_hold;
    bit m_lap, m_ovf, m_done;

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int t;
        t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int preset_value(input logic [W-1:0] b);
        int s, wgt, d;
        s = 0;
        wgt = 1;
        for (int i = 0; i < ND; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            s = s + d * wgt;
            wgt = wgt * 10;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_hold = 0;
        m_lap = 0; m_ovf = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit run, tk;
        run = start && !(mode && m_done);
        if (clear) begin
            model_reset();
        end else if (load) begin
            m_cnt = preset_value(preset);
            m_pre = 0; m_lap = 0; m_ovf = 0; m_done = 0;
        end else begin
            tk = 0;
            if (run) begin
                if (m_pre == TD - 1) begin tk = 1; m_pre = 0; end
                else m_pre = m_pre + 1;
            end
            if (lap) begin
                if (!m_lap) begin m_hold = m_cnt; m_lap = 1; end
                else m_lap = 0;
            end
            if (tk) begin
                if (!mode) begin
                    if (m_cnt == MAXV) begin m_cnt = 0; m_ovf = 1; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt <= 1) begin m_cnt = 0; m_done = 1; end
                    else m_cnt = m_cnt - 1;
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm);
        logic [19:0] act, exp;
        bit erun;
        erun = start && !(mode && m_done);
        act = {digits, lap_active, overflow, done, running};
        exp = {int2bcd(m_lap ? m_hold : m_cnt), m_lap, m_ovf, m_done, erun};
        check(nm, 32'(act), 32'(exp));
    endtask

    // One rising edge; inputs are stable, the model follows the same edge,
    // and sampling happens 1 time unit later.
    task automatic step();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Called away from the rising edge; checks outputs while reset is held.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_async");
        #1;
        reset = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         st, clr, ld, md, lp;
        logic [W-1:0] pre;
        logic [W-1:0] e_dig;
        logic         e_lap, e_ovf, e_done, e_run;
    } vec_t;

    function automatic vec_t mk(input logic st, clr, ld, md, lp, input logic [W-1:0] pre,
                                input logic [W-1:0] e_dig, input logic e_lap, e_ovf, e_done, e_run);
        vec_t v;
        v.st = st; v.clr = clr; v.ld = ld; v.md = md; v.lp = lp; v.pre = pre;
        v.e_dig = e_dig; v.e_lap = e_lap; v.e_ovf = e_ovf; v.e_done = e_done; v.e_run = e_run;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        //                st clr ld md lp preset     digits    lap ovf dn run
        tbl[0]  = mk(0, 0, 1, 0, 0, 16'h0999, 16'h0999, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0999, 0, 0, 0, 1);
        tbl[2]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0999, 0, 0, 0, 1);
        tbl[3]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0999, 0, 0, 0, 1);
        tbl[4]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h1000, 0, 0, 0, 1);
        tbl[5]  = mk(0, 0, 1, 0, 0, 16'h9999, 16'h9999, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, 0, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1);
        tbl[10] = mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 0, 0, 16'h0A12, 16'h0912, 0, 0, 0, 0);
        tbl[12] = mk(0, 1, 1, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 0, 16'h1234, 16'h1234, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 0, 1, 16'h0042, 16'h0042, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 1, 16'h0000, 16'h0042, 1, 0, 0, 0);
        tbl[16] = mk(0, 0, 1, 0, 0, 16'h0007, 16'h0007, 0, 0, 0, 0);

        // ---------------- reset and table ----------------
        do_reset();
        for (int i = 0; i < 17; i++) begin
            start = tbl[i].st; clear = tbl[i].clr; load = tbl[i].ld;
            mode = tbl[i].md; lap = tbl[i].lp; preset = tbl[i].pre;
            step();
            check($sformatf("table_row%0d", i),
                  32'({digits, lap_active, overflow, done, running}),
                  32'({tbl[i].e_dig, tbl[i].e_lap, tbl[i].e_ovf, tbl[i].e_done, tbl[i].e_run}));
        end
        start = 0; clear = 0; load = 0; mode = 0; lap = 0; preset = '0;
        step();

        // ---------------- basic count ----------------
        do_reset();
        start = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (e == 3) check("basic_e3", 32'(digits), 32'h0000);
            if (e == 4) check("basic_e4", 32'(digits), 32'h0001);
        end
        check("basic_e40", 32'(digits), 32'h0010);
        check("basic_running", 32'(running), 32'h1);

        // ---------------- countdown to done ----------------
        start = 1'b0; pulse_clear();
        preset = 16'h0003; mode = 1'b1; load = 1'b1; start = 1'b1;
        step();
        load = 1'b0;
        check("down_load", 32'(digits), 32'h0003);
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 4) check("down_t1", 32'(digits), 32'h0002);
            if (e == 8) check("down_t2", 32'({digits, done}), 32'({16'h0001, 1'b0}));
        end
        check("down_t3", 32'({digits, done, running}), 32'({16'h0000, 1'b1, 1'b0}));
        steps(20);
        check("down_frozen", 32'({digits, done, running}), 32'({16'h0000, 1'b1, 1'b0}));
        // A frozen prescaler sits at 0, so switching to up needs a full period.
        mode = 1'b0;
        steps(3);
        check("down_pre_frozen", 32'(digits), 32'h0000);
        step();
        check("down_then_up", 32'({digits, done}), 32'({16'h0001, 1'b1}));

        // ---------------- lap hold ----------------
        start = 1'b0; pulse_clear();
        start = 1'b1;
        steps(20);
        check("lap_pre", 32'(digits), 32'h0005);
        lap = 1'b1; step(); lap = 1'b0;
        check("lap_set", 32'({digits, lap_active}), 32'({16'h0005, 1'b1}));
        steps(11);
        check("lap_frozen", 32'({digits, lap_active}), 32'({16'h0005, 1'b1}));
        lap = 1'b1; step(); lap = 1'b0;
        check("lap_release", 32'({digits, lap_active}), 32'({16'h0008, 1'b0}));

        // ---------------- pause mid-period ----------------
        start = 1'b0; pulse_clear();
        start = 1'b1; steps(2);
        start = 1'b0; steps(10);
        check("pause_hold", 32'(digits), 32'h0000);
        start = 1'b1; step();
        check("pause_resume1", 32'(digits), 32'h0000);
        step();
        check("pause_resume2", 32'(digits), 32'h0001);

        // ---------------- asynchronous reset mid-count ----------------
        preset = 16'h9999; load = 1'b1; step(); load = 1'b0;
        steps(4);
        lap = 1'b1; step(); lap = 1'b0;
        steps(2);
        check("prereset_state", 32'({digits, lap_active, overflow}), 32'({16'h0000, 1'b1, 1'b1}));
        start = 1'b0;
        do_reset();
        check("reset_outputs", 32'({digits, lap_active, overflow, done, running}), 32'h0);
        start = 1'b1;
        steps(4);
        check("reset_resume", 32'(digits), 32'h0001);

        // ---------------- randomized against the model ----------------
        for (int n = 0; n < 3000; n++) begin
            int r;
            start = ($urandom_range(99) < 85);
            clear = ($urandom_range(99) < 2);
            load  = ($urandom_range(99) < 4);
            lap   = ($urandom_range(99) < 6);
            if ($urandom_range(99) < 3) mode = ~mode;
            r = $urandom_range(3);
            case (r)
                0: preset = 16'($urandom);
                1: preset = int2bcd($urandom_range(4));
                2: preset = int2bcd(9990 + $urandom_range(9));
                default: preset = int2bcd($urandom_range(MAXV));
            endcase
            if ($urandom_range(999) < 3) begin
                do_reset();
            end else begin
                step();
                check_all("random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stop_watch_lap.md
# stop_watch_lap

Parametrised BCD stopwatch for the stopwatch display path. It counts in `DIGITS` decimal digits at a rate of one count per `TICK_DIV` clock cycles, either up or down. It adds three behaviours: preset load, a lap hold that freezes the display while counting continues underneath, and sticky overflow/done flags. It drives the seven-segment digit multiplexer directly, with digit 0 as the least significant digit.

## Interface
- `TICK_DIV`, default 4: clock cycles per count step; legal range ≥1 (1 means a step every enabled cycle).
- `DIGITS`, default 4: number of BCD digits; legal range 1..8.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `start`  in  1: level input; the prescaler advances while high and holds while low.
- `clear`  in  1: synchronous one-cycle pulse; zeroes the count, prescaler, flags and lap hold.
- `load`   in  1: synchronous one-cycle pulse; count ← `preset`.
- `preset` in  4*DIGITS: BCD preset; digit n occupies bits [4n+3:4n].
- `mode`   in  1: 0 = count up, 1 = count down.
- `lap`    in  1: one-cycle pulse; toggles the lap hold.
- `digits` out 4*DIGITS: displayed BCD value; digit 0 in bits [3:0].
- `lap_active` out 1: display is frozen.
- `overflow`   out 1: sticky; the up count wrapped.
- `done`       out 1: sticky; the down count reached zero.
- `running`    out 1: combinational; equals `start & ~(mode & done)`.

## Operation
- State:
  - BCD count register `cnt`.
  - Prescaler `pre` in the range 0..TICK_DIV-1.
  - Lap register `hold` and lap flag.
  - `overflow` and `done` flags.
- Prescaler:
  - When `running` is high, `pre` increments.
  - When `pre` == TICK_DIV-1, a tick occurs and `pre` returns to 0.
  - When `running` is low, `pre` holds its value.
- Up tick:
  - Ripple BCD increment: each digit goes 9→0 and carries into the next digit.
  - From all-9s, `cnt` wraps to all-0s and `overflow` is set.
- Down tick:
  - Ripple BCD decrement: each digit goes 0→9 and borrows from the next digit.
  - When the result is 0, `done` is set.
  - A tick with `cnt` already at 0 leaves `cnt` at 0 and sets `done`.
  - With `done` set in down mode, `running` = 0 and the prescaler freezes.
- Load:
  - `cnt` ← `preset`. Any nibble greater than 9 is clamped to 9.
  - `pre` ← 0; `overflow` and `done` ← 0; lap hold released.
- Clear: `cnt`, `pre`, `overflow`, `done`, lap flag and `hold` all ← 0.
- Lap:
  - If not holding: `hold` ← the pre-edge `cnt` (the value currently displayed) and the lap flag is set.
  - If holding: the lap flag is cleared.
  - Counting is never affected by lap.
- Display: `digits` = `hold` when the lap flag is set, otherwise `cnt`.
- Priority on any edge: `reset` > `clear` > `load` > tick. A `lap` pulse in the same cycle as `clear` or `load` is ignored.
- Mode changes take effect at the next tick. The prescaler phase is unaffected, and the flags are not cleared.

## Timing
- Reset values: `digits` = 0, `lap_active` = 0, `overflow` = 0, `done` = 0; internal `pre`, `cnt` and `hold` = 0. `running` then follows `start`.
- Every output except `running` is registered.
- `start` rising with `pre` = 0: the first count step is visible after the TICK_DIV-th rising edge at which `start` is sampled high.
- Dropping `start` mid-period keeps the residual `pre` value. Resuming completes the remaining edges of that period before the next tick.
- `load`, `clear` and `lap` are visible on the outputs one edge after they are sampled.
- Flags are set on the same edge as the tick that causes them.
- Asserting `reset` mid-count forces all outputs to their reset values without waiting for a clock edge. After release, counting resumes from zero at the first edge with `start` high.

## Test plan
All scenarios use TICK_DIV=4 and DIGITS=4.
- **Basic count:** Reset, then hold `start` high → `digits` reads 0x0001 after edge 4 and 0x0010 after edge 40; `running` = 1.
- **Carry and wrap:** Load 0x0999 and run up → one tick gives 0x1000. Load 0x9999 and run up → one tick gives 0x0000 with `overflow` = 1; a later `clear` returns `overflow` to 0.
- **Countdown to done:** Load 0x0003 with `mode` = 1 → 0x0002, 0x0001, 0x0000 on successive ticks, with `done` = 1 on the third. `running` = 0; 20 further edges keep 0x0000 and the prescaler frozen.
- **Lap hold:** Count to 0x0005, then pulse `lap` → `digits` holds 0x0005 and `lap_active` = 1 for 3 ticks. A second `lap` pulse shows 0x0008.
- **Pause mid-period:** Drop `start` for 10 edges after 2 enabled edges → no step occurs. After resuming, the step lands on the 2nd enabled edge.
- **Priority and reset:**
  - `clear` and `load` (preset 0x1234) together → 0x0000.
  - `load` 0x0A12 → 0x0912 (nibble clamped).
  - Asynchronous `reset` mid-count → all outputs 0 before the next edge.
